// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_pkg;

  localparam int unsigned SYM_W_DEF = 2;

  // Reference target 00,10,11,01; the oldest symbol sits in the LSBs.
  localparam logic [7:0] REF_PATTERN = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// Symbol history: DEPTH x SYM_W shift register, newest symbol enters at the MSB end.
module seq_shift_hist #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic [SYM_W-1:0]         x_i,
  output logic [DEPTH*SYM_W-1:0]   hist_o
);

  localparam int unsigned HistW = DEPTH * SYM_W;

  logic [HistW-1:0] hist_d, hist_q;

  always_comb begin
    hist_d = hist_q;
    if (flush_i) begin
      hist_d = '0;
    end else if (en_i) begin
      hist_d = {x_i, hist_q[HistW-1:SYM_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;

endmodule

// File: rtl/seq_detector_param.sv
// Flags when the last DEPTH enabled symbols equal a loadable pattern; counts matches.
module seq_detector_param
  import seq_pkg::*;
#(
  parameter int unsigned SYM_W   = SYM_W_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned MEALY   = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [SYM_W-1:0]          x,
  input  logic                      load,
  input  logic [DEPTH*SYM_W-1:0]    pattern,
  output logic                      z,
  output logic [fill_w(DEPTH)-1:0]  fill,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int unsigned FillW = fill_w(DEPTH);
  localparam int unsigned PatW  = DEPTH * SYM_W;

  logic [PatW-1:0]  hist;
  logic [PatW-1:0]  window;
  logic [PatW-1:0]  pat_d, pat_q;
  logic [FillW-1:0] fill_d, fill_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             z_d, z_q;
  logic             hit;

  seq_shift_hist #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en & ~load),
    .flush_i (load),
    .x_i     (x),
    .hist_o  (hist)
  );

  // Candidate window: current symbol as newest plus the DEPTH-1 most recent held symbols.
  assign window = {x, hist[PatW-1:SYM_W]};

  // load discards the symbol on the same cycle, so it can never complete a match.
  assign hit = en && !load && (fill_q >= FillW'(DEPTH - 1)) && (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    z_d    = 1'b0;
    if (load) begin
      pat_d  = pattern;
      fill_d = '0;
    end else if (en) begin
      fill_d = (fill_q == FillW'(DEPTH)) ? fill_q : fill_q + FillW'(1);
      if (hit) begin
        z_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (OVERLAP == 0) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end

  assign z         = (MEALY != 0) ? hit : z_q;
  assign fill      = fill_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: five detector configurations share one stimulus stream.
module tb_seq_detector_param;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] x = 2'b00;
  logic [7:0] pat4 = '0;
  logic [3:0] pat2 = '0;

  logic       z0, z1, z2, z3, z4;
  logic [2:0] f0, f3;
  logic [1:0] f1, f2, f4;
  logic [7:0] c0, c1, c2, c3;
  logic [1:0] c4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0 default Moore, u1/u2 DEPTH=2 overlap/non-overlap, u3 Mealy, u4 2-bit counter
  seq_detector_param #(.SYM_W(2), .DEPTH(4), .OVERLAP(1), .MEALY(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern(pat4),
    .z(z0), .fill(f0), .match_cnt(c0));
  seq_detector_param #(.SYM_W(2), .DEPTH(2), .OVERLAP(1), .MEALY(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern(pat2),
    .z(z1), .fill(f1), .match_cnt(c1));
  seq_detector_param #(.SYM_W(2), .DEPTH(2), .OVERLAP(0), .MEALY(0), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern(pat2),
    .z(z2), .fill(f2), .match_cnt(c2));
  seq_detector_param #(.SYM_W(2), .DEPTH(4), .OVERLAP(1), .MEALY(1), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern(pat4),
    .z(z3), .fill(f3), .match_cnt(c3));
  seq_detector_param #(.SYM_W(2), .DEPTH(2), .OVERLAP(1), .MEALY(0), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern(pat2),
    .z(z4), .fill(f4), .match_cnt(c4));

  typedef struct {
    int    id;
    logic  z;
    int    fill;
    int    cnt;
    string nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic az;
  int   af, ac;

  // Expected values for the current cycle; sampled at the following negedge.
  task automatic chk(input int id, input logic ez, input int ef, input int ec, input string nm);
    exp_t t;
    t.id = id; t.z = ez; t.fill = ef; t.cnt = ec; t.nm = nm;
    q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.id)
        0: begin az = z0; af = int'(f0); ac = int'(c0); end
        1: begin az = z1; af = int'(f1); ac = int'(c1); end
        2: begin az = z2; af = int'(f2); ac = int'(c2); end
        3: begin az = z3; af = int'(f3); ac = int'(c3); end
        default: begin az = z4; af = int'(f4); ac = int'(c4); end
      endcase
      checks++;
      if (az !== e.z || af != e.fill || ac != e.cnt) begin
        errors++;
        $display("FAIL %s u%0d at %0t: got z=%0b fill=%0d cnt=%0d, expected z=%0b fill=%0d cnt=%0d",
                 e.nm, e.id, $time, az, af, ac, e.z, e.fill, e.cnt);
      end
    end
  end

  logic [1:0] seq4 [4];

  initial begin
    seq4[0] = 2'b00; seq4[1] = 2'b10; seq4[2] = 2'b11; seq4[3] = 2'b01;
    @(posedge clk);
    #1;

    // Reset held while symbols are offered
    rst = 1'b1; en = 1'b1; x = 2'b11;
    for (int i = 0; i < 3; i++) begin
      chk(0, 1'b0, 0, 0, "rst_hold");
      tick();
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk(0, 1'b0, 0, 0, "rst_release");
      tick();
    end

    pat4 = REF_PATTERN;
    pat2 = 4'b11_11;
    load = 1'b1;
    chk(0, 1'b0, 0, 0, "load_init");
    tick();
    load = 1'b0;

    // Basic Moore detection, Mealy instance checked on the same stream
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; x = seq4[i];
      chk(0, 1'b0, i, 0, "t2_sym");
      if (i == 3) chk(3, 1'b1, 3, 0, "t2_mealy_same_cycle");
      tick();
    end
    en = 1'b0;
    chk(0, 1'b1, 4, 1, "t2_moore_z");
    tick();
    chk(0, 1'b0, 4, 1, "t2_z_single");
    tick();

    load = 1'b1;
    chk(0, 1'b0, 4, 1, "t4_load");
    tick();
    load = 1'b0;

    // Mealy with two idle cycles between symbols
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; x = seq4[i];
      chk(3, (i == 3), i, 1, "t4_mealy_sym");
      tick();
      en = 1'b0;
      for (int g = 0; g < 2; g++) begin
        chk(3, 1'b0, i + 1, (i == 3) ? 2 : 1, "t4_mealy_gap");
        tick();
      end
    end
    chk(0, 1'b0, 4, 2, "t4_moore_cnt");
    load = 1'b1;
    tick();
    load = 1'b0;

    // Overlap vs non-overlap on DEPTH=2, pattern 11,11
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; x = 2'b11;
      chk(1, (k >= 2), (k < 2) ? k : 2, (k < 2) ? 0 : k - 1, "t3_overlap");
      chk(2, (k == 2), k % 2, k / 2, "t3_nonoverlap");
      tick();
    end
    en = 1'b0;
    chk(1, 1'b1, 2, 3, "t3_overlap_end");
    chk(2, 1'b1, 0, 2, "t3_nonoverlap_end");
    tick();

    load = 1'b1;
    chk(0, 1'b0, 4, 2, "t5_load");
    tick();
    load = 1'b0;

    // load beats en on the final symbol
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; x = seq4[i];
      chk(0, 1'b0, i, 2, "t5_prefix");
      tick();
    end
    load = 1'b1; en = 1'b1; x = 2'b01;
    chk(0, 1'b0, 3, 2, "t5_load_with_en");
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; x = seq4[i];
      chk(0, 1'b0, i, 2, "t5_after_load");
      tick();
    end
    en = 1'b0;
    chk(0, 1'b1, 4, 3, "t5_one_match");
    tick();
    chk(0, 1'b0, 4, 3, "t5_no_extra");
    tick();

    // Asynchronous reset clears within the cycle
    rst = 1'b1;
    chk(0, 1'b0, 0, 0, "async_rst");
    chk(4, 1'b0, 0, 0, "async_rst_u4");
    tick();
    rst = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;

    // Saturating 2-bit counter: five matches
    for (int k = 0; k < 6; k++) begin
      en = 1'b1; x = 2'b11;
      chk(4, (k >= 2), (k < 2) ? k : 2, (k < 2) ? 0 : ((k - 1 > 3) ? 3 : k - 1), "t6_sat");
      tick();
    end
    en = 1'b0;
    chk(4, 1'b1, 2, 3, "t6_sat_end");
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
